// File: rtl/mult_defs_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding and default sizes.
package mult_defs;

  localparam int MULT_WIDTH = 64;
  localparam int MULT_CNT_W = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_64_acc_adder.sv
// Combinational accumulate step: acc + mcand when the current multiplier bit is set, else acc.
module mult_acc_adder #(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic               i_en,
  output logic [2*WIDTH-1:0] o_sum
);

  assign o_sum = i_en ? (i_acc + i_mcand) : i_acc;

endmodule

// File: rtl/seq_mult_64.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock, Start/Busy/Done handshake.
// Optional MULT_EARLY_TERM_EN: leave RUN as soon as no set multiplier bits remain.
module seq_mult_64
  import mult_defs::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  state_t               r_state;
  state_t               w_next_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_accept;
  logic                 w_last;

  mult_acc_adder #(.WIDTH(WIDTH)) u_adder (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_en    (r_mplier[0]),
    .o_sum   (w_sum)
  );

  // Start is only honoured when no operation is in flight (IDLE or DONE).
  assign w_accept = Start && (r_state != S_RUN);

`ifdef MULT_EARLY_TERM_EN
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (r_mplier[WIDTH-1:1] == '0);
`else
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_RUN;
      S_RUN:   if (w_last)   w_next_state = S_DONE;
      S_DONE:  w_next_state = w_accept ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, A};
      r_mplier <= B;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      // Product only moves on the final RUN edge and holds otherwise.
      if (w_last) r_product <= w_sum;
    end
  end

  assign Busy    = (r_state == S_RUN);
  assign Done    = (r_state == S_DONE);
  assign Product = r_product;

endmodule

// File: tb/tb_seq_mult_64.sv
// Self-checking bench for seq_mult_64: directed corner cases plus randomized operands vs an arithmetic model.
module tb_seq_mult_64;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [63:0]  A;
  logic [63:0]  B;
  logic         Busy;
  logic         Done;
  logic [127:0] Product;

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] prev_product = '0;

  seq_mult_64 dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] ref_product(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] wa, wb;
    wa = {64'd0, a};
    wb = {64'd0, b};
    return wa * wb;
  endfunction

  function automatic int ref_latency(input logic [63:0] b);
`ifdef MULT_EARLY_TERM_EN
    int m = 0;
    for (int i = 0; i < 64; i++) if (b[i]) m = i + 1;
    return (m < 1) ? 1 : m;
`else
    return 64;
`endif
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Drive Start for the edge that samples it (edge 0); afterwards scramble A/B.
  task automatic issue(input logic [63:0] a, input logic [63:0] b);
    @(negedge Clk);
    Start = 1'b1;
    A = a;
    B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    A = rand64();
    B = rand64();
    check("busy_after_start", 128'(Busy), 128'(1));
    check("product_held_in_run", Product, prev_product);
  endtask

  // Counts edges until Done is seen; lat = 0 if the bound expires.
  task automatic wait_done(input int max_edges, output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= max_edges; n++) begin
      @(posedge Clk);
      #1;
      if (Done) begin
        lat = n;
        break;
      end
      if (!Busy) busy_ok = 1'b0;
    end
  endtask

  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b);
    int lat;
    bit busy_ok;
    issue(a, b);
    wait_done(200, lat, busy_ok);
    check({tag, "_latency"}, 128'(lat), 128'(ref_latency(b)));
    check({tag, "_busy"}, 128'(busy_ok), 128'(1));
    check({tag, "_product"}, Product, ref_product(a, b));
    prev_product = ref_product(a, b);
    @(posedge Clk);
    #1;
    check({tag, "_done_1cyc"}, {126'd0, Busy, Done}, 128'd0);
    check({tag, "_product_hold"}, Product, prev_product);
  endtask

  initial begin
    int lat;
    bit busy_ok;
    int pulses;
    logic [63:0] a1, b1;

    Reset = 1'b1;
    Start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_state", {Product, 6'd0, Busy, Done}, 136'd0);
    @(negedge Clk);
    Reset = 1'b0;

    do_op("mul_3x5", 64'd3, 64'd5);
    do_op("b_zero", 64'hDEAD_BEEF, 64'd0);
    do_op("a_zero", 64'd0, rand64());
    do_op("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check("all_ones_const", Product, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    do_op("b_one", rand64(), 64'd1);

    // Asynchronous reset in the middle of an operation.
    issue(rand64(), 64'h8000_0000_0000_0001);
    repeat (30) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset_mid_run", {Product, 6'd0, Busy, Done}, 136'd0);
    prev_product = '0;
    @(negedge Clk);
    Reset = 1'b0;
    do_op("after_reset", 64'd12345, 64'd678);

    // Start pulsed during RUN with different operands must be ignored.
    a1 = rand64();
    b1 = rand64() | 64'h8000_0000_0000_0000;
    issue(a1, b1);
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    Start = 1'b1;
    A = rand64();
    B = 64'd1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    check("start_in_run_busy", 128'(Busy), 128'(1));
    wait_done(200, lat, busy_ok);
    check("start_in_run_latency", 128'(lat + 11), 128'(ref_latency(b1)));
    check("start_in_run_busy_all", 128'(busy_ok), 128'(1));
    check("start_in_run_product", Product, ref_product(a1, b1));
    prev_product = ref_product(a1, b1);
    @(posedge Clk);
    #1;

    // Back-to-back issue: Start held high through DONE.
    issue(64'd2, 64'd3);
    wait_done(200, lat, busy_ok);
    check("b2b_first_product", Product, 128'd6);
    Start = 1'b1;
    A = 64'd7;
    B = 64'd9;
    @(posedge Clk);
    #1;
    check("b2b_accept", {126'd0, Busy, Done}, 128'd2);
    check("b2b_hold_6", Product, 128'd6);
    A = rand64();
    B = rand64();
    lat = 0;
    pulses = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge Clk);
      #1;
      if (Done) begin
        lat = n;
        pulses++;
        break;
      end
    end
    check("b2b_second_latency", 128'(lat), 128'(ref_latency(64'd9)));
    check("b2b_second_product", Product, 128'd63);
    @(posedge Clk);
    #1;
    check("b2b_done_once", {126'd0, Busy, Done}, 128'd2);
    check("b2b_pulse_count", 128'(pulses), 128'd1);
    Start = 1'b0;
    wait_done(200, lat, busy_ok);
    prev_product = ref_product(A, B);
    check("b2b_third_product", Product, prev_product);
    @(posedge Clk);
    #1;

    // Randomized operands with a mix of widths for B.
    for (int k = 0; k < 14; k++) begin
      logic [63:0] ra, rb;
      ra = rand64();
      case (k % 3)
        0: rb = rand64();
        1: rb = 64'($urandom_range(0, 255));
        default: rb = rand64() >> $urandom_range(0, 63);
      endcase
      do_op($sformatf("rand%0d", k), ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
